// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants and shared types for the instruction encoder.
package rv_isa_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [6:0] F7_ADD     = 7'b0000000;
   localparam logic [6:0] F7_SUB     = 7'b0100000;

   typedef enum logic [1:0] {
      ENC_ADD  = 2'b00,
      ENC_SUB  = 2'b01,
      ENC_ADDI = 2'b10,
      ENC_RSVD = 2'b11
   } enc_op_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } enc_entry_t;

endpackage

// File: rtl/instr_encode_if.sv
// Valid/ready stream carrying an encoded instruction word and its PC.
interface instr_encode_if;

   logic        valid;
   logic        ready;
   logic [31:0] instr;
   logic [31:0] pc;

   modport master (output valid, output instr, output pc, input ready);
   modport slave  (input valid, input instr, input pc, output ready);

endinterface

// File: rtl/enc_fifo.sv
// Two-entry in-order FIFO of {instr, pc}; head presented on a stream interface.
module enc_fifo
   import rv_isa_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  enc_entry_t push_data,
   output logic       full,
   instr_encode_if.master deq
);

   enc_entry_t mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic       do_push;
   logic       do_pop;

   assign full    = (count == 2'd2);
   assign do_push = push & ~full;
   assign do_pop  = deq.valid & deq.ready;

   assign deq.valid = (count != 2'd0);
   assign deq.instr = deq.valid ? mem[rd_ptr].instr : '0;
   assign deq.pc    = deq.valid ? mem[rd_ptr].pc    : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         count <= count + 2'(do_push) - 2'(do_pop);
      end
   end

   // NOTE: storage has no reset; count gates every read so stale data never escapes.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/instr_encode.sv
// Encodes ADD/SUB/ADDI requests into RV32I words, tags them with a PC and buffers them.
module instr_encode
   import rv_isa_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enc_valid,
   output logic        o_enc_ready,
   input  logic [1:0]  i_enc_op,
   input  logic [4:0]  i_enc_rd_idx,
   input  logic [4:0]  i_enc_rs1_idx,
   input  logic [4:0]  i_enc_rs2_idx,
   input  logic [11:0] i_enc_imm,
   input  logic        i_enc_pc_load,
   input  logic [31:0] i_enc_pc_value,
   output logic        o_enc_valid,
   input  logic        i_enc_ready,
   output logic [31:0] o_enc_instr,
   output logic [31:0] o_enc_pc,
   output logic        o_enc_err
);

   enc_op_e     op;
   logic [31:0] instr;
   logic [31:0] next_pc;
   logic [31:0] load_pc;
   logic [31:0] tag_pc;
   logic        full;
   logic        accept;
   logic        push;
   logic        err_q;
   enc_entry_t  push_data;

   instr_encode_if deq_if ();

   assign op = enc_op_e'(i_enc_op);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      instr = '0;
      unique case (op)
         ENC_ADD:  instr = {F7_ADD, i_enc_rs2_idx, i_enc_rs1_idx, F3_ADD_SUB, i_enc_rd_idx, OPC_OP};
         ENC_SUB:  instr = {F7_SUB, i_enc_rs2_idx, i_enc_rs1_idx, F3_ADD_SUB, i_enc_rd_idx, OPC_OP};
         ENC_ADDI: instr = {i_enc_imm, i_enc_rs1_idx, F3_ADD_SUB, i_enc_rd_idx, OPC_OP_IMM};
         ENC_RSVD: instr = '0;
      endcase
   end

   assign load_pc     = i_enc_pc_value & ~32'h0000_0003;
   assign tag_pc      = i_enc_pc_load ? load_pc : next_pc;
   assign o_enc_ready = ~full & ~i_rst;
   assign accept      = i_enc_valid & o_enc_ready;
   assign push        = accept & (op != ENC_RSVD);
   assign push_data   = '{instr: instr, pc: tag_pc};

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         next_pc <= RESET_PC;
         err_q   <= 1'b0;
      end else begin
         err_q <= accept & (op == ENC_RSVD);
         if (push)               next_pc <= tag_pc + 32'd4;
         else if (i_enc_pc_load) next_pc <= load_pc;
      end
   end

   enc_fifo u_fifo (
      .clk       (i_clk),
      .rst       (i_rst),
      .push      (push),
      .push_data (push_data),
      .full      (full),
      .deq       (deq_if)
   );

   assign deq_if.ready = i_enc_ready;

   // Reset is synchronous, so outputs are also masked during the reset cycle itself.
   assign o_enc_valid = deq_if.valid & ~i_rst;
   assign o_enc_instr = i_rst ? '0 : deq_if.instr;
   assign o_enc_pc    = i_rst ? '0 : deq_if.pc;
   assign o_enc_err   = err_q & ~i_rst;

endmodule

// File: tb/tb_instr_encode.sv
// Directed bench for instr_encode with a queue-based reference model checked every cycle.
module tb_instr_encode;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        enc_valid;
   logic        enc_ready_out;
   logic [1:0]  enc_op;
   logic [4:0]  rd_idx, rs1_idx, rs2_idx;
   logic [11:0] imm;
   logic        pc_load;
   logic [31:0] pc_value;
   logic        enc_err;

   instr_encode_if mon ();

   instr_encode #(.RESET_PC(RESET_PC)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_enc_valid    (enc_valid),
      .o_enc_ready    (enc_ready_out),
      .i_enc_op       (enc_op),
      .i_enc_rd_idx   (rd_idx),
      .i_enc_rs1_idx  (rs1_idx),
      .i_enc_rs2_idx  (rs2_idx),
      .i_enc_imm      (imm),
      .i_enc_pc_load  (pc_load),
      .i_enc_pc_value (pc_value),
      .o_enc_valid    (mon.valid),
      .i_enc_ready    (mon.ready),
      .o_enc_instr    (mon.instr),
      .o_enc_pc       (mon.pc),
      .o_enc_err      (enc_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc(input logic [1:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [11:0] im);
      case (op)
         2'd0:    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
         2'd1:    return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
         2'd2:    return {im, rs1, 3'b000, rd, 7'b0010011};
         default: return 32'h0;
      endcase
   endfunction

   // Reference model: what the block should hold after each clock edge.
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   exp_t        q[$];
   logic [31:0] m_pc;
   logic        m_err;
   logic [31:0] emitted[$];

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_pc  = RESET_PC;
         m_err = 1'b0;
      end else begin
         automatic bit acc = enc_valid && (q.size() < 2);
         automatic bit pop = (q.size() > 0) && mon.ready;
         automatic logic [31:0] ld = {pc_value[31:2], 2'b00};
         m_err = acc && (enc_op == 2'd3);
         if (pop) void'(q.pop_front());
         if (acc && enc_op != 2'd3) begin
            automatic logic [31:0] tag = pc_load ? ld : m_pc;
            q.push_back('{instr: enc(enc_op, rd_idx, rs1_idx, rs2_idx, imm), pc: tag});
            m_pc = tag + 32'd4;
         end else if (pc_load) begin
            m_pc = ld;
         end
      end
   end

   always @(negedge clk) begin
      automatic bit ev = !rst && (q.size() > 0);
      check("valid", {31'b0, mon.valid}, {31'b0, ev});
      check("ready", {31'b0, enc_ready_out}, {31'b0, !rst && (q.size() < 2)});
      check("err",   {31'b0, enc_err}, {31'b0, !rst && m_err});
      check("instr", mon.instr, ev ? q[0].instr : 32'h0);
      check("pc",    mon.pc,    ev ? q[0].pc    : 32'h0);
      if (mon.valid && mon.ready) emitted.push_back(mon.pc);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [11:0] im,
                        input logic ld, input logic [31:0] ldv);
      enc_valid = 1'b1;
      enc_op    = op;
      rd_idx    = rd;
      rs1_idx   = rs1;
      rs2_idx   = rs2;
      imm       = im;
      pc_load   = ld;
      pc_value  = ldv;
      tick();
      enc_valid = 1'b0;
      pc_load   = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) tick();
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      enc_valid = 1'b0;
      enc_op    = 2'd0;
      rd_idx    = '0;
      rs1_idx   = '0;
      rs2_idx   = '0;
      imm       = '0;
      pc_load   = 1'b0;
      pc_value  = '0;
      mon.ready = 1'b1;

      // Reset state and ready in the first cycle after reset
      repeat (2) tick();
      @(negedge clk);
      check("rst_valid", {31'b0, mon.valid}, 32'd0);
      check("rst_ready", {31'b0, enc_ready_out}, 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", {31'b0, enc_ready_out}, 32'd1);

      // ADD, SUB, ADDI with literal encodings
      tick();
      issue(2'd0, 5'd3, 5'd1, 5'd2, 12'h000, 1'b0, 32'h0);
      @(negedge clk);
      check("add_valid", {31'b0, mon.valid}, 32'd1);
      check("add_instr", mon.instr, 32'h002081B3);
      check("add_pc",    mon.pc,    32'h00000000);
      tick();
      issue(2'd1, 5'd5, 5'd6, 5'd7, 12'h000, 1'b0, 32'h0);
      @(negedge clk);
      check("sub_instr", mon.instr, 32'h407302B3);
      check("sub_pc",    mon.pc,    32'h00000004);
      tick();
      issue(2'd2, 5'd1, 5'd0, 5'd0, 12'hFFF, 1'b0, 32'h0);
      @(negedge clk);
      check("addi_instr", mon.instr, 32'hFFF00093);
      check("addi_pc",    mon.pc,    32'h00000008);
      repeat (2) tick();

      // Backpressure: two buffered, third stalls, then drain in order
      do_reset(2);
      mon.ready = 1'b0;
      emitted.delete();
      issue(2'd0, 5'd1, 5'd1, 5'd1, 12'h0, 1'b0, 32'h0);
      issue(2'd0, 5'd2, 5'd2, 5'd2, 12'h0, 1'b0, 32'h0);
      enc_valid = 1'b1;
      enc_op    = 2'd0;
      rd_idx    = 5'd3;
      tick();
      @(negedge clk);
      check("full_ready", {31'b0, enc_ready_out}, 32'd0);
      check("stall_instr", mon.instr, 32'h001080B3);
      check("stall_pc",    mon.pc,    32'h00000000);
      tick();
      @(negedge clk);
      check("stall_instr_hold", mon.instr, 32'h001080B3);
      check("stall_pc_hold",    mon.pc,    32'h00000000);
      mon.ready = 1'b1;
      repeat (2) tick();
      enc_valid = 1'b0;
      repeat (4) tick();
      check("drain_count", emitted.size(), 32'd3);
      if (emitted.size() == 3) begin
         check("drain_pc0", emitted[0], 32'h0);
         check("drain_pc1", emitted[1], 32'h4);
         check("drain_pc2", emitted[2], 32'h8);
      end

      // PC load with accept, then wrap past 2^32
      emitted.delete();
      issue(2'd0, 5'd4, 5'd4, 5'd4, 12'h0, 1'b1, 32'hFFFF_FFFE);
      issue(2'd0, 5'd5, 5'd5, 5'd5, 12'h0, 1'b0, 32'h0);
      repeat (3) tick();
      check("wrap_count", emitted.size(), 32'd2);
      if (emitted.size() == 2) begin
         check("wrap_pc0", emitted[0], 32'hFFFF_FFFC);
         check("wrap_pc1", emitted[1], 32'h0000_0000);
      end

      // Reserved op: one-cycle error pulse, nothing enqueued, PC unchanged
      emitted.delete();
      issue(2'd3, 5'd6, 5'd6, 5'd6, 12'h0, 1'b0, 32'h0);
      @(negedge clk);
      check("rsvd_err",   {31'b0, enc_err},   32'd1);
      check("rsvd_valid", {31'b0, mon.valid}, 32'd0);
      tick();
      @(negedge clk);
      check("rsvd_err_off", {31'b0, enc_err}, 32'd0);
      tick();
      issue(2'd0, 5'd7, 5'd7, 5'd7, 12'h0, 1'b0, 32'h0);
      repeat (3) tick();
      check("rsvd_count", emitted.size(), 32'd1);
      if (emitted.size() == 1) check("rsvd_next_pc", emitted[0], 32'h4);

      // Reset with two entries buffered
      mon.ready = 1'b0;
      issue(2'd0, 5'd8, 5'd8, 5'd8, 12'h0, 1'b0, 32'h0);
      issue(2'd0, 5'd9, 5'd9, 5'd9, 12'h0, 1'b0, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", {31'b0, mon.valid}, 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_valid", {31'b0, mon.valid}, 32'd0);
      check("post_rst_ready", {31'b0, enc_ready_out}, 32'd1);
      mon.ready = 1'b1;
      emitted.delete();
      tick();
      issue(2'd0, 5'd10, 5'd10, 5'd10, 12'h0, 1'b0, 32'h0);
      repeat (3) tick();
      check("post_rst_count", emitted.size(), 32'd1);
      if (emitted.size() == 1) check("post_rst_pc", emitted[0], RESET_PC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_encode.md
INSTR_ENCODE -- requirements
Module: instr_encode

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC assigned to the first instruction after reset.
REQ-002 SHALL have port i_clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port i_enc_valid, input, 1: an encode request is present.
REQ-005 SHALL have port o_enc_ready, output, 1: block can accept a request.
REQ-006 SHALL have port i_enc_op, input, 2: 00 ADD, 01 SUB, 10 ADDI, 11 reserved.
REQ-007 SHALL have ports i_enc_rd_idx, i_enc_rs1_idx and i_enc_rs2_idx, inputs, 5 each: register indices.
REQ-008 SHALL have port i_enc_imm, input, 12: ADDI immediate; ignored for ADD and SUB.
REQ-009 SHALL have ports i_enc_pc_load (input, 1) and i_enc_pc_value (input, 32): PC redirect.
REQ-010 SHALL have port o_enc_valid, output, 1: an encoded instruction is presented.
REQ-011 SHALL have port i_enc_ready, input, 1: downstream accepts the instruction.
REQ-012 SHALL have ports o_enc_instr (output, 32) and o_enc_pc (output, 32): encoded word and its PC.
REQ-013 SHALL have port o_enc_err, output, 1: one-cycle pulse on a reserved-op request.

Function
REQ-014 SHALL accept a request when i_enc_valid and o_enc_ready are both 1 at a clock edge.
REQ-015 SHALL encode ADD as {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011}.
REQ-016 SHALL encode SUB as {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011}.
REQ-017 SHALL encode ADDI as {imm, rs1, 3'b000, rd, 7'b0010011}.
REQ-018 SHALL encode rd = 0 unmodified, with no filtering.
REQ-019 SHALL buffer encoded instructions in a 2-entry in-order FIFO holding {instr, pc}.
REQ-020 SHALL drive o_enc_ready = !full, with no same-cycle bypass when full.
REQ-021 SHALL present an accepted instruction on the output no earlier than the cycle after acceptance (latency 1).
REQ-022 SHALL pop the head when o_enc_valid and i_enc_ready are both 1.
REQ-023 SHALL allow a simultaneous push and pop when not full, leaving occupancy unchanged.
REQ-024 SHALL hold o_enc_instr and o_enc_pc stable while o_enc_valid is 1 and i_enc_ready is 0.
REQ-025 SHALL drive o_enc_instr and o_enc_pc to 0 whenever o_enc_valid is 0.
REQ-026 SHALL keep a next_pc register and tag each enqueued instruction with next_pc.
REQ-027 SHALL then set next_pc = next_pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-028 On i_enc_pc_load, SHALL set next_pc to {i_enc_pc_value[31:2], 2'b00}.
REQ-029 On i_enc_pc_load in the same cycle as an accept, SHALL tag that instruction with the loaded PC and set next_pc to loaded PC + 4.
REQ-030 On an accepted op 11, SHALL complete the handshake, enqueue nothing, leave next_pc unchanged, and pulse o_enc_err for exactly one cycle on the following cycle.
REQ-031 SHALL keep o_enc_err at 0 at all other times.

Reset
REQ-032 While i_rst is 1, SHALL empty the FIFO and set next_pc to RESET_PC.
REQ-033 While i_rst is 1, SHALL hold o_enc_valid = 0, o_enc_err = 0, o_enc_instr = 0, o_enc_pc = 0 and o_enc_ready = 0.
REQ-034 SHALL assert o_enc_ready in the first cycle after i_rst falls.
REQ-035 On reset mid-operation, SHALL discard buffered entries and emit nothing from them afterwards.

Structure
REQ-036 SHALL take the opcode constants (7'b0110011, 7'b0010011), funct3/funct7 values and the 2-bit op enumeration from a shared package rv_isa_pkg.
REQ-037 SHALL implement the FIFO as sub-module enc_fifo (2-entry synchronous FIFO, 64-bit payload).
REQ-038 SHALL implement the encoder as combinational logic in instr_encode.

Verification
REQ-039 Reset, then ADD rd=3 rs1=1 rs2=2 -> next cycle o_enc_valid=1, o_enc_instr=0x002081B3, o_enc_pc=0x00000000.
REQ-040 Then SUB rd=5 rs1=6 rs2=7 -> o_enc_instr=0x407302B3, o_enc_pc=0x00000004.
REQ-041 ADDI rd=1 rs1=0 imm=0xFFF -> o_enc_instr=0xFFF00093.
REQ-042 i_enc_ready=0, three back-to-back requests -> o_enc_ready=0 after two accepts, output stable; then i_enc_ready=1 -> all three emitted in order with PCs 0x0, 0x4, 0x8.
REQ-043 pc_load 0xFFFF_FFFE with an ADD accept, then a second ADD -> PCs 0xFFFF_FFFC then 0x0000_0000.
REQ-044 op=11 accepted -> o_enc_err high exactly one cycle, no output, next ADD gets the unchanged PC.
REQ-045 Two entries buffered, then i_rst for one cycle -> o_enc_valid=0 and next PC = RESET_PC.
